// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-boundary widths and control-vector bit encoding.
// Every stage imports this so producers and consumers agree on control bits.
package pipe_pkg;

    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IDEX_DATA_W  = 96;
    localparam int unsigned EXMEM_DATA_W = 96;
    localparam int unsigned MEMWB_DATA_W = 64;

    localparam int unsigned CTRL_W_DEF = 16;
    localparam int unsigned DEST_W_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 16;

    // Control-vector bit positions; all are zeroed when a bubble is inserted.
    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMREAD  = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;
    localparam int unsigned CTRL_MEMTOREG = 3;
    localparam int unsigned CTRL_BRANCH   = 4;
    localparam int unsigned CTRL_JUMP     = 5;
    localparam int unsigned CTRL_ALUSRC   = 6;
    localparam int unsigned CTRL_ALUOP_LO = 7;
    localparam int unsigned CTRL_ALUOP_HI = 10;

    typedef enum logic [1:0] {
        STAGE_IFID  = 2'd0,
        STAGE_IDEX  = 2'd1,
        STAGE_EXMEM = 2'd2,
        STAGE_MEMWB = 2'd3
    } pipe_stage_e;

    // Payload width carried across a given stage boundary.
    function automatic int unsigned stage_data_w(input pipe_stage_e stage);
        int unsigned w;
        w = IDEX_DATA_W;
        case (stage)
            STAGE_IFID:  w = IFID_DATA_W;
            STAGE_IDEX:  w = IDEX_DATA_W;
            STAGE_EXMEM: w = EXMEM_DATA_W;
            STAGE_MEMWB: w = MEMWB_DATA_W;
            default:     w = IDEX_DATA_W;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake, payload and debug bundle between a pipeline stage register and
// its neighbours; master is the surrounding pipeline, slave is the register.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IDEX_DATA_W,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) ();

    logic              flush;
    logic              bubble;

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DEST_W-1:0] in_dest;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DEST_W-1:0] out_dest;
    logic              out_dest_valid;
    logic [DATA_W-1:0] out_data;

    logic              hazard_d;
    logic [CNT_W-1:0]  bubble_cnt;

    modport master (
        output flush, bubble,
        output in_valid, in_ctrl, in_dest, in_data,
        input  in_ready,
        input  out_valid, out_ctrl, out_dest, out_dest_valid, out_data,
        output out_ready,
        input  hazard_d, bubble_cnt
    );

    modport slave (
        input  flush, bubble,
        input  in_valid, in_ctrl, in_dest, in_data,
        output in_ready,
        output out_valid, out_ctrl, out_dest, out_dest_valid, out_data,
        input  out_ready,
        output hazard_d, bubble_cnt
    );

endinterface

// File: rtl/pipe_stage_reg_entry.sv
// One stage-register entry {valid, ctrl, dest, dest_valid, data}.
// Clear empties the entry but keeps dest/data; load applies bubble form on request.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF,
    parameter int unsigned DATA_W = IDEX_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              bubble_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DEST_W-1:0] dest_i,
    input  logic              dest_valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DEST_W-1:0] dest_o,
    output logic              dest_valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q,      valid_d;
    logic [CTRL_W-1:0] ctrl_q,       ctrl_d;
    logic [DEST_W-1:0] dest_q,       dest_d;
    logic              dest_valid_q, dest_valid_d;
    logic [DATA_W-1:0] data_q,       data_d;

    // Clear wins over load; a bubble keeps the tag and payload but kills ctrl and tag validity.
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        dest_d       = dest_q;
        dest_valid_d = dest_valid_q;
        data_d       = data_q;
        if (clear_i) begin
            valid_d      = 1'b0;
            ctrl_d       = '0;
            dest_valid_d = 1'b0;
        end else if (load_i) begin
            valid_d      = 1'b1;
            ctrl_d       = bubble_i ? '0 : ctrl_i;
            dest_d       = dest_i;
            dest_valid_d = dest_valid_i & ~bubble_i;
            data_d       = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            dest_q       <= '0;
            dest_valid_q <= 1'b0;
            data_q       <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            dest_q       <= dest_d;
            dest_valid_q <= dest_valid_d;
            data_q       <= data_d;
        end
    end

    assign valid_o      = valid_q;
    assign ctrl_o       = ctrl_q;
    assign dest_o       = dest_q;
    assign dest_valid_o = dest_valid_q;
    assign data_o       = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: main + skid entry with valid/ready back-pressure,
// synchronous flush, bubble insertion, hazard history and saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IDEX_DATA_W,
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DEST_W = DEST_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input logic clk,
    input logic rst_n,
    pipe_stage_reg_if.slave bus
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DEST_W-1:0] main_dest;
    logic              main_dest_valid;
    logic [DATA_W-1:0] main_data;

    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DEST_W-1:0] skid_dest;
    logic              skid_dest_valid;
    logic [DATA_W-1:0] skid_data;

    logic              accept_c;
    logic              drain_c;
    logic              main_load_c;
    logic              main_clear_c;
    logic              main_sel_skid_c;
    logic              skid_load_c;
    logic              skid_clear_c;

    logic [CTRL_W-1:0] main_ctrl_in_c;
    logic [DEST_W-1:0] main_dest_in_c;
    logic              main_dest_valid_in_c;
    logic [DATA_W-1:0] main_data_in_c;
    logic              main_bubble_in_c;

    logic              hazard_q, hazard_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;

    // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
    assign accept_c = bus.in_valid & ~skid_valid;
    assign drain_c  = main_valid & bus.out_ready;

    // Entry steering: flush, then refill main (skid first), otherwise park the new entry in skid.
    always_comb begin
        main_load_c     = 1'b0;
        main_clear_c    = 1'b0;
        main_sel_skid_c = 1'b0;
        skid_load_c     = 1'b0;
        skid_clear_c    = 1'b0;
        if (bus.flush) begin
            main_clear_c = 1'b1;
            skid_clear_c = 1'b1;
        end else if (!main_valid || drain_c) begin
            if (skid_valid) begin
                main_load_c     = 1'b1;
                main_sel_skid_c = 1'b1;
                skid_clear_c    = 1'b1;
            end else if (accept_c) begin
                main_load_c = 1'b1;
            end else begin
                main_clear_c = 1'b1;
            end
        end else if (accept_c) begin
            skid_load_c = 1'b1;
        end
    end

    // Skid contents are already in final form, so bubble shaping applies only to the input path.
    always_comb begin
        main_ctrl_in_c       = bus.in_ctrl;
        main_dest_in_c       = bus.in_dest;
        main_dest_valid_in_c = 1'b1;
        main_data_in_c       = bus.in_data;
        main_bubble_in_c     = bus.bubble;
        if (main_sel_skid_c) begin
            main_ctrl_in_c       = skid_ctrl;
            main_dest_in_c       = skid_dest;
            main_dest_valid_in_c = skid_dest_valid;
            main_data_in_c       = skid_data;
            main_bubble_in_c     = 1'b0;
        end
    end

    pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DEST_W (DEST_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (main_load_c),
        .clear_i      (main_clear_c),
        .bubble_i     (main_bubble_in_c),
        .ctrl_i       (main_ctrl_in_c),
        .dest_i       (main_dest_in_c),
        .dest_valid_i (main_dest_valid_in_c),
        .data_i       (main_data_in_c),
        .valid_o      (main_valid),
        .ctrl_o       (main_ctrl),
        .dest_o       (main_dest),
        .dest_valid_o (main_dest_valid),
        .data_o       (main_data)
    );

    pipe_skid_entry #(
        .CTRL_W (CTRL_W),
        .DEST_W (DEST_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (skid_load_c),
        .clear_i      (skid_clear_c),
        .bubble_i     (bus.bubble),
        .ctrl_i       (bus.in_ctrl),
        .dest_i       (bus.in_dest),
        .dest_valid_i (1'b1),
        .data_i       (bus.in_data),
        .valid_o      (skid_valid),
        .ctrl_o       (skid_ctrl),
        .dest_o       (skid_dest),
        .dest_valid_o (skid_dest_valid),
        .data_o       (skid_data)
    );

    // A bubble counts only if its entry really enters the stage (not dropped by flush).
    always_comb begin
        hazard_d = bus.bubble;
        cnt_d    = cnt_q;
        if (accept_c && bus.bubble && !bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hazard_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            hazard_q <= hazard_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready       = ~skid_valid;
    assign bus.out_valid      = main_valid;
    assign bus.out_ctrl       = main_ctrl;
    assign bus.out_dest       = main_dest;
    assign bus.out_dest_valid = main_dest_valid;
    assign bus.out_data       = main_data;
    assign bus.hazard_d       = hazard_q;
    assign bus.bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue model of held entries predicts
// handshake and payload; a second instance with a 2-bit counter checks saturation.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 96;
    localparam int unsigned CTRL_W = 16;
    localparam int unsigned DEST_W = 5;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DEST_W-1:0] dest;
        logic              dv;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEST_W(DEST_W), .CNT_W(16)) ifa ();
    pipe_stage_reg_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEST_W(DEST_W), .CNT_W(2))  ifb ();

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEST_W(DEST_W), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEST_W(DEST_W), .CNT_W(2)) dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    assign ifb.flush     = ifa.flush;
    assign ifb.bubble    = ifa.bubble;
    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_ctrl   = ifa.in_ctrl;
    assign ifb.in_dest   = ifa.in_dest;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.out_ready = ifa.out_ready;

    entry_t      q[$];
    int unsigned bub_total = 0;
    logic        exp_haz = 1'b0;
    bit          mon_en = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus; called at posedge+1, returns at the following posedge+1.
    task automatic cycle(input logic v, input logic bub, input logic fl, input logic ordy,
                         input logic [CTRL_W-1:0] ctrl, input logic [DEST_W-1:0] dest,
                         input logic [DATA_W-1:0] data);
        bit     acc;
        entry_t e;
        ifa.in_valid  = v;
        ifa.bubble    = bub;
        ifa.flush     = fl;
        ifa.out_ready = ordy;
        ifa.in_ctrl   = ctrl;
        ifa.in_dest   = dest;
        ifa.in_data   = data;
        acc    = v && (q.size() < 2);
        e.ctrl = bub ? '0 : ctrl;
        e.dest = dest;
        e.dv   = !bub;
        e.data = data;
        @(posedge clk);
        if (fl) q.delete();
        else if (acc) q.push_back(e);
        if (acc && bub && !fl) bub_total++;
        exp_haz = bub;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Monitor: compare presented outputs with the model; pop the front when it drains.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("in_ready", 128'(ifa.in_ready), 128'(q.size() < 2));
            check("out_valid", 128'(ifa.out_valid), 128'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_ctrl", 128'(ifa.out_ctrl), 128'(q[0].ctrl));
                check("out_dest", 128'(ifa.out_dest), 128'(q[0].dest));
                check("out_dest_valid", 128'(ifa.out_dest_valid), 128'(q[0].dv));
                check("out_data", 128'(ifa.out_data), 128'(q[0].data));
                if (ifa.out_ready) void'(q.pop_front());
            end else begin
                check("empty_ctrl", 128'(ifa.out_ctrl), 128'(0));
                check("empty_dest_valid", 128'(ifa.out_dest_valid), 128'(0));
            end
            check("hazard_d", 128'(ifa.hazard_d), 128'(exp_haz));
            check("bubble_cnt", 128'(ifa.bubble_cnt), 128'(bub_total > 65535 ? 65535 : bub_total));
            check("bubble_cnt_w2", 128'(ifb.bubble_cnt), 128'(bub_total > 3 ? 3 : bub_total));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 128'(ifa.out_valid), 128'(0));
        check({tag, "_in_ready"}, 128'(ifa.in_ready), 128'(1));
        check({tag, "_out_ctrl"}, 128'(ifa.out_ctrl), 128'(0));
        check({tag, "_out_dest"}, 128'(ifa.out_dest), 128'(0));
        check({tag, "_out_dv"}, 128'(ifa.out_dest_valid), 128'(0));
        check({tag, "_out_data"}, 128'(ifa.out_data), 128'(0));
        check({tag, "_hazard_d"}, 128'(ifa.hazard_d), 128'(0));
        check({tag, "_bubble_cnt"}, 128'(ifa.bubble_cnt), 128'(0));
        check({tag, "_bubble_cnt_w2"}, 128'(ifb.bubble_cnt), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic v, bub, fl, ordy;
        ifa.in_valid = 1'b0; ifa.bubble = 1'b0; ifa.flush = 1'b0; ifa.out_ready = 1'b0;
        ifa.in_ctrl = '0; ifa.in_dest = '0; ifa.in_data = '0;
        #3;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Back-to-back stream, downstream always ready.
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, DEST_W'(i), DATA_W'(i));
        idle(2);

        // Back-pressure: A into main, B into skid, C refused, then drain in order.
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0003, 5'd1, DATA_W'(32'hA));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 5'd2, DATA_W'(32'hB));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0009, 5'd3, DATA_W'(32'hC));
        idle(3);

        // Bubble insertion keeps tag and payload, zeroes ctrl, invalidates the tag.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 5'd7, DATA_W'(32'h55));
        idle(2);

        // Bubble with nothing offered creates no entry and no count.
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 5'd9, DATA_W'(32'h66));
        idle(1);

        // Flush with both entries full and a new entry offered.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 5'd4, DATA_W'(32'h111));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 5'd5, DATA_W'(32'h222));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 16'h3333, 5'd6, DATA_W'(32'h333));
        idle(2);

        // Randomised traffic with flushes and bubbles.
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom % 4) != 0;
            bub  = ($urandom % 5) == 0;
            fl   = ($urandom % 16) == 0;
            ordy = ($urandom % 3) != 0;
            if (fl && v) bub = 1'b0;
            cycle(v, bub, fl, ordy, 16'($urandom), 5'($urandom), rnd_data());
        end

        // Asynchronous reset with both entries held.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hABCD, 5'd10, rnd_data());
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'hBCDE, 5'd11, rnd_data());
        #2;
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.bubble = 1'b0; ifa.flush = 1'b0; ifa.out_ready = 1'b0;
        #1;
        check_reset_state("async_reset");
        q.delete();
        bub_total = 0;
        exp_haz = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Five accepted bubbles: the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'hFFFF, 5'(i), rnd_data());
        idle(2);

        for (int i = 0; i < 150; i++) begin
            v    = ($urandom % 3) != 0;
            bub  = ($urandom % 4) == 0;
            fl   = ($urandom % 20) == 0;
            ordy = ($urandom % 2) != 0;
            if (fl && v) bub = 1'b0;
            cycle(v, bub, fl, ordy, 16'($urandom), 5'($urandom), rnd_data());
        end
        idle(4);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
